// File: rtl/dlfloat_pkg.sv
// dlfloat_pkg: DLFloat format defaults, flag indices, classify helpers and pipeline payload types
package dlfloat_pkg;
  localparam int DLF_EXP_W = 6;
  localparam int DLF_MAN_W = 9;
  localparam int DLF_BIAS = 31;
  localparam int DLF_TAG_W = 4;
  localparam int DLF_W = 1 + DLF_EXP_W + DLF_MAN_W;
  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_NX = 0;
  function automatic logic is_special(input logic [DLF_W-2:0] em);
    return &em;
  endfunction
  function automatic logic is_zero(input logic [DLF_W-2:0] em);
    return em[DLF_W-2 -: DLF_EXP_W] == '0;
  endfunction
  typedef struct packed {
    logic s;
    logic [DLF_EXP_W+1:0] e;
    logic [DLF_MAN_W:0] ma;
    logic [DLF_MAN_W:0] mb;
    logic special;
    logic inv;
    logic zero;
    logic rnd;
    logic [DLF_TAG_W-1:0] tag;
  } s1_t;
  typedef struct packed {
    logic s;
    logic [DLF_EXP_W+1:0] e;
    logic [2*DLF_MAN_W+1:0] prod;
    logic special;
    logic inv;
    logic zero;
    logic rnd;
    logic [DLF_TAG_W-1:0] tag;
  } s2_t;
endpackage

// File: rtl/dlf_round_norm.sv
// dlf_round_norm: combinational normalise, round, exception select and pack
// ports: s/e/prod = sign, biased exponent (two's complement, EXP_W+2 bits), raw mantissa product;
//        rnd = 0 nearest-even / 1 truncate; special/inv/zero = operand class; z/flags = packed result
module dlf_round_norm
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W
) (
  input  logic                       s,
  input  logic [EXP_W+1:0]           e,
  input  logic [2*MAN_W+1:0]         prod,
  input  logic                       rnd,
  input  logic                       special,
  input  logic                       inv,
  input  logic                       zero,
  output logic [EXP_W+MAN_W:0]       z,
  output logic [3:0]                 flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int PW = 2 * MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  logic top, g, st, inc, c;
  logic [PW-1:0] pn;
  logic [MAN_W-1:0] man, mr;
  logic [EW-1:0] e2;
  always_comb begin
    top = prod[PW-1];
    pn = top ? prod : prod << 1;
    man = pn[PW-2 -: MAN_W];
    g = pn[MAN_W];
    st = |pn[MAN_W-1:0];
    inc = !rnd && g && (st || man[0]);
    {c, mr} = {1'b0, man} + (MAN_W+1)'(inc);
    e2 = e + EW'(top) + EW'(c);
    z = {s, e2[EXP_W-1:0], mr};
    flags = '0;
    if (special) begin
      z = {s, {(W-1){1'b1}}};
      flags[FLG_INV] = inv;
    end else if (zero) begin
      z = {s, {(W-1){1'b0}}};
    end else if (e2[EW-1] || e2 == '0) begin
      z = {s, {(W-1){1'b0}}};
      flags[FLG_UNF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else if (e2 > EMAX || (e2 == EMAX && &mr)) begin
      // all-ones mantissa at the top exponent would encode SPECIAL, so it overflows too
      z = {s, {(W-1){1'b1}}};
      flags[FLG_OVF] = 1'b1;
      flags[FLG_NX] = 1'b1;
    end else begin
      flags[FLG_NX] = g || st;
    end
  end
endmodule

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: 3-stage valid/ready DLFloat multiplier with tag passthrough and IEEE-style flags
// ports: in_valid/in_ready/in_a/in_b/in_tag/rnd_mode = operand side;
//        out_valid/out_ready/out_z/out_tag/out_flags = result side, flags {inv,ovf,unf,nx}
module fp_mult_pipe
  import dlfloat_pkg::*;
#(
  parameter int EXP_W = DLF_EXP_W,
  parameter int MAN_W = DLF_MAN_W,
  parameter int BIAS = DLF_BIAS,
  parameter int TAG_W = DLF_TAG_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic                   rnd_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_z,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  s1_t s1, n1;
  s2_t s2, n2;
  logic v1, v2, v3, ld1, ld2, ld3;
  logic sp_a, sp_b, z_a, z_b;
  logic [W-1:0] z3;
  logic [3:0] f3;
  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign ld1 = !v1 || ld2;
  assign in_ready = ld1;
  assign out_valid = v3;
  always_comb begin
    sp_a = is_special(in_a[W-2:0]);
    sp_b = is_special(in_b[W-2:0]);
    z_a = is_zero(in_a[W-2:0]);
    z_b = is_zero(in_b[W-2:0]);
    n1.s = in_a[W-1] ^ in_b[W-1];
    n1.e = EW'(in_a[W-2 -: EXP_W]) + EW'(in_b[W-2 -: EXP_W]) - EW'(BIAS);
    n1.ma = {1'b1, in_a[MAN_W-1:0]};
    n1.mb = {1'b1, in_b[MAN_W-1:0]};
    n1.special = sp_a || sp_b;
    n1.inv = (sp_a && z_b) || (sp_b && z_a);
    n1.zero = z_a || z_b;
    n1.rnd = rnd_mode;
    n1.tag = in_tag;
    n2.s = s1.s;
    n2.e = s1.e;
    n2.prod = PW'(s1.ma) * PW'(s1.mb);
    n2.special = s1.special;
    n2.inv = s1.inv;
    n2.zero = s1.zero;
    n2.rnd = s1.rnd;
    n2.tag = s1.tag;
  end
  dlf_round_norm #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_rn (
    .s(s2.s), .e(s2.e), .prod(s2.prod), .rnd(s2.rnd),
    .special(s2.special), .inv(s2.inv), .zero(s2.zero),
    .z(z3), .flags(f3)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      s1 <= '0;
      s2 <= '0;
      out_z <= '0;
      out_tag <= '0;
      out_flags <= '0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld1 && in_valid) s1 <= n1;
      if (ld2) v2 <= v1;
      if (ld2 && v1) s2 <= n2;
      if (ld3) v3 <= v2;
      if (ld3 && v2) begin
        out_z <= z3;
        out_tag <= s2.tag;
        out_flags <= f3;
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: directed vector table plus streaming, backpressure and reset sequences
module tb_fp_mult_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [3:0] in_tag = '0;
  logic rnd_mode = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] out_z;
  logic [3:0] out_tag;
  logic [3:0] out_flags;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  fp_mult_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .rnd_mode(rnd_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_tag(out_tag), .out_flags(out_flags)
  );
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic rnd;
    logic [15:0] z;
    logic [3:0] f;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic send_one(input int i);
    int n;
    @(negedge clk);
    in_a = vecs[i].a;
    in_b = vecs[i].b;
    rnd_mode = vecs[i].rnd;
    in_tag = 4'(i);
    in_valid = 1'b1;
    #1 chk("vec_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1 n++;
    end
    chk($sformatf("vec%0d_latency", i), 32'(n), 32'd3);
    chk($sformatf("vec%0d_z", i), 32'(out_z), 32'(vecs[i].z));
    chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].f));
    chk($sformatf("vec%0d_tag", i), 32'(out_tag), 32'(i));
    @(posedge clk);
  endtask
  initial begin
    int sent, rcv, stale;
    logic held, saw_block;
    logic [15:0] hz;
    vecs[0] = '{16'h3E00, 16'h4000, 1'b0, 16'h4000, 4'b0000};
    vecs[1] = '{16'h3F00, 16'h3F00, 1'b0, 16'h4040, 4'b0000};
    vecs[2] = '{16'h3E01, 16'h3F00, 1'b0, 16'h3F02, 4'b0001};
    vecs[3] = '{16'h3E01, 16'h3F00, 1'b1, 16'h3F01, 4'b0001};
    vecs[4] = '{16'h7C00, 16'h7C00, 1'b0, 16'h7FFF, 4'b0101};
    vecs[5] = '{16'h0200, 16'h0200, 1'b0, 16'h0000, 4'b0011};
    vecs[6] = '{16'hFFFF, 16'h3E00, 1'b0, 16'hFFFF, 4'b0000};
    vecs[7] = '{16'h0000, 16'h7FFF, 1'b0, 16'h7FFF, 4'b1000};
    vecs[8] = '{16'h8000, 16'h3E00, 1'b0, 16'h8000, 4'b0000};
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_z", 32'(out_z), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_flags", 32'(out_flags), 32'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 9; i++) send_one(i);
    sent = 0;
    rcv = 0;
    held = 1'b0;
    saw_block = 1'b0;
    hz = '0;
    for (int cyc = 0; cyc < 40 && rcv < 6; cyc++) begin
      @(negedge clk);
      in_valid = sent < 6;
      in_a = 16'h3E00;
      in_b = 16'h4000 + 16'(sent);
      in_tag = 4'(sent);
      rnd_mode = 1'b0;
      out_ready = !(cyc >= 3 && cyc < 8);
      #1;
      if (out_valid) begin
        if (held) chk("stall_hold_z", 32'(out_z), 32'(hz));
        if (!out_ready) begin
          held = 1'b1;
          hz = out_z;
        end else begin
          held = 1'b0;
          chk($sformatf("stream%0d_z", rcv), 32'(out_z), 32'(16'h4000 + 16'(rcv)));
          chk($sformatf("stream%0d_tag", rcv), 32'(out_tag), 32'(rcv));
          chk($sformatf("stream%0d_flags", rcv), 32'(out_flags), 32'd0);
          rcv++;
        end
      end
      if (in_valid && !in_ready) begin
        saw_block = 1'b1;
        chk("stream_buffered", 32'(sent - rcv), 32'd3);
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    chk("stream_count", 32'(rcv), 32'd6);
    chk("stream_backpressure", 32'(saw_block), 32'd1);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 16'h3E00;
      in_b = 16'h3F00;
      in_tag = 4'(k + 8);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("pre_reset_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 32'(out_valid), 32'd0);
    chk("async_reset_z", 32'(out_z), 32'd0);
    chk("async_reset_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    stale = 0;
    repeat (6) begin
      @(posedge clk);
      #1 if (out_valid) stale++;
    end
    chk("no_stale_results", 32'(stale), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
